fifo_sc_fwft: RTL
=================

Name: fifo_sc_fwft

Overview:
Parametrised single-clock soft FIFO, the successor to the current single-clock FIFO wrapper for datapath buffering between decoder stages.
- Adds a selectable first-word-fall-through (FWFT) read mode.
- Adds independent prog_full and prog_empty thresholds.
- Adds a registered fill-level output.
- Never destroys contents on overflow or underflow; uses inferred dual-port RAM storage.

Parameters:
dta_width, 8, data bus width in bits
addr_width, 8, log2 of depth; depth = 2^addr_width entries
full_thresh, 1, prog_full asserts when free entries <= full_thresh
empty_thresh, 1, prog_empty asserts when level <= empty_thresh
fwft, 0, 0 = standard read (data one cycle after rd_en); 1 = first-word-fall-through

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-low master reset
din  in  dta_width  write data
wr_en  in  1  write request
full  out  1  level == depth
wr_ack  out  1  previous-cycle write accepted
overflow  out  1  previous-cycle write rejected (full)
prog_full  out  1  level >= depth - full_thresh
dout  out  dta_width  read data
rd_en  in  1  read request (standard) / pop acknowledge (fwft)
empty  out  1  no word readable
valid  out  1  standard: previous-cycle read succeeded; fwft: dout holds head word
underflow  out  1  previous-cycle read rejected (empty)
prog_empty  out  1  level <= empty_thresh
level  out  addr_width+1  words held, including any fwft output-stage word

Behaviour:
- Reset: clk rising edge with rst=0 clears the pointers and level, and discards contents.
  - Outputs after reset: level=0, dout=0, full=0, wr_ack=0, overflow=0, prog_full=0, valid=0, underflow=0, empty=1, prog_empty=1.
  - Reset mid-operation has the same effect; a wr_en or rd_en in the reset cycle is ignored.
- Pointers: wr_ptr and rd_ptr are addr_width bits and wrap modulo depth. Level is tracked in an (addr_width+1)-bit counter, never derived from the pointers.
- Write:
  - wr_en & ~full: store din at wr_ptr, wr_ptr+1, wr_ack=1 next cycle.
  - wr_en & full: nothing stored, overflow=1 next cycle.
  - full is evaluated on the registered level. A write while full is rejected even if a read occurs in the same cycle.
- Standard read (fwft=0):
  - rd_en & ~empty: dout <= ram[rd_ptr], rd_ptr+1, valid=1 next cycle.
  - rd_en & empty: dout holds, underflow=1 next cycle.
  - dout holds whenever no read is accepted.
  - empty = (level==0). A write and read in the same cycle on an empty FIFO: write accepted, read underflows.
- FWFT read (fwft=1):
  - One output-stage register is prefetched from RAM whenever it is empty or being popped and RAM holds data.
  - valid=1 while the output stage holds a word; empty = ~valid.
  - rd_en & valid pops the head. The next word, if present, is shown the following cycle, with no bubble on back-to-back pops.
  - rd_en & ~valid: underflow=1 next cycle.
  - Latency: a word written into an empty FIFO at edge N appears on dout with valid=1 after edge N+1. level becomes 1 after edge N, so level=1 with empty=1 for one cycle is legal.
- Level: after each edge, level = level + accepted_write − accepted_read (net 0 when both are accepted).
- Flags: full, prog_full and prog_empty are registered, computed from the next-state level, and therefore coincide with level.
- wr_ack, overflow, valid (standard mode) and underflow are single-cycle pulses.

Optional Feature:
FIFO_PEAK_LEVEL_EN:
- When defined, adds output port peak_level [addr_width:0] and input port peak_clr (1 bit).
- peak_level is a high-water mark: it is updated to the new level whenever the new level exceeds it.
- peak_clr=1 loads peak_level with the current level; peak_clr has priority over the update.
- Reset clears peak_level to 0.
- When the macro is undefined, neither port exists and no logic is generated.

Test Plan:
Defaults for all scenarios: dta_width=8, addr_width=4 (depth 16), full_thresh=2, empty_thresh=2.
1. Reset, then write 0x01..0x10 with fwft=0 → full=1 after the 16th write, level=16, prog_full=1 from level 14, one extra write gives overflow=1 and the contents are unchanged. Then 16 reads return 0x01..0x10 in order, and empty=1 after the last read.
2. Read on empty with fwft=0 → underflow=1 for exactly one cycle, dout unchanged, level stays 0.
3. Fill to level 16, then assert wr_en and rd_en together → write rejected (overflow=1), read accepted, level=15, next read data is the correct FIFO head.
4. fwft=1: write 0xA5 at edge N → valid=1 and dout=0xA5 after edge N+1. Write 0x3C, 0x7E, then hold rd_en for 3 cycles → dout sequence is 0xA5, 0x3C, 0x7E with no bubbles, then empty=1.
5. Stream 40 words with sustained simultaneous read and write at level 5 → level stays 5 and the pointers wrap past 15. Assert rst=0 mid-stream → next cycle level=0, empty=1, valid=0, dout=0.
6. With FIFO_PEAK_LEVEL_EN defined: fill to 9, drain to 3 → peak_level=9. Pulse peak_clr → peak_level=3.

Source files
------------

// File: rtl/fifo_sc_fwft.sv
// fifo_sc_fwft: single-clock FIFO with a selectable first-word-fall-through read mode.
//
// Storage is an inferred dual-port RAM of 2**addr_width words. The fill level is kept in its own
// (addr_width+1)-bit counter rather than derived from the pointers. Overflow and underflow never
// corrupt contents or pointers.
//
// Parameters:
//   dta_width    data width in bits
//   addr_width   log2 of depth
//   full_thresh  prog_full asserts when free entries <= full_thresh
//   empty_thresh prog_empty asserts when level <= empty_thresh
//   fwft         0 = standard read (dout one cycle after rd_en), 1 = first-word-fall-through
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-low reset
//   din, wr_en   write data / request
//   full         level == depth
//   wr_ack       previous-cycle write accepted (pulse)
//   overflow     previous-cycle write rejected because full (pulse)
//   prog_full    level >= depth - full_thresh
//   dout, rd_en  read data / read request (standard) or pop acknowledge (fwft)
//   empty        no word readable
//   valid        standard: previous-cycle read succeeded (pulse); fwft: dout holds the head word
//   underflow    previous-cycle read rejected because empty (pulse)
//   prog_empty   level <= empty_thresh
//   level        words held, including a word parked in the fwft output stage
//
// Optional build macro FIFO_PEAK_LEVEL_EN adds:
//   peak_clr     load the high-water mark with the current level
//   peak_level   high-water mark of level since reset or the last peak_clr

module fifo_sc_fwft #(
  parameter int unsigned dta_width    = 8,
  parameter int unsigned addr_width   = 8,
  parameter int unsigned full_thresh  = 1,
  parameter int unsigned empty_thresh = 1,
  parameter bit          fwft         = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [dta_width-1:0]  din,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  prog_full,
  output logic [dta_width-1:0]  dout,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  valid,
  output logic                  underflow,
  output logic                  prog_empty,
`ifdef FIFO_PEAK_LEVEL_EN
  input  logic                  peak_clr,
  output logic [addr_width:0]   peak_level,
`endif
  output logic [addr_width:0]   level
);

  localparam int unsigned Depth = 1 << addr_width;
  localparam int unsigned LvW   = addr_width + 1;

  localparam logic [addr_width:0] DepthLv    = LvW'(Depth);
  localparam logic [addr_width:0] ProgFullLv = LvW'(Depth - full_thresh);
  localparam logic [addr_width:0] ProgEmptLv = LvW'(empty_thresh);

  logic [dta_width-1:0]  mem [Depth];

  logic [addr_width-1:0] wr_ptr_q, rd_ptr_q;
  logic [addr_width:0]   level_q, level_d;
  logic [addr_width:0]   ram_cnt;
  logic [dta_width-1:0]  dout_q;
  logic                  full_q, prog_full_q, prog_empty_q;
  logic                  wr_ack_q, overflow_q, underflow_q;
  logic                  valid_q, valid_d;
  logic                  wr_accept, rd_accept, ram_rd, rd_empty;

  // Next-state decode. Full is taken from the registered flag, so a write while full is refused
  // even if a read frees a slot in the same cycle.
  always_comb begin
    wr_accept = wr_en & ~full_q;
    // Words still in RAM; in fwft mode the output stage holds one more.
    ram_cnt   = level_q - LvW'(fwft & valid_q);
    rd_empty  = 1'b1;
    rd_accept = 1'b0;
    ram_rd    = 1'b0;
    valid_d   = 1'b0;
    if (fwft) begin
      rd_empty  = ~valid_q;
      rd_accept = rd_en & valid_q;
      // Refill the output stage when it is empty or being popped this cycle.
      ram_rd    = (~valid_q | rd_accept) & (ram_cnt != '0);
      valid_d   = ram_rd | (valid_q & ~rd_accept);
    end else begin
      rd_empty  = (level_q == '0);
      rd_accept = rd_en & ~rd_empty;
      ram_rd    = rd_accept;
      valid_d   = rd_accept;
    end
    level_d = level_q + LvW'(wr_accept) - LvW'(rd_accept);
  end

  // Storage: no reset, contents are discarded by clearing pointers and level.
  always_ff @(posedge clk) begin
    if (rst && wr_accept) begin
      mem[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      dout_q       <= '0;
      full_q       <= 1'b0;
      prog_full_q  <= 1'b0;
      prog_empty_q <= 1'b1;
      wr_ack_q     <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (ram_rd) begin
        dout_q   <= mem[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      level_q      <= level_d;
      full_q       <= (level_d == DepthLv);
      prog_full_q  <= (level_d >= ProgFullLv);
      prog_empty_q <= (level_d <= ProgEmptLv);
      wr_ack_q     <= wr_accept;
      overflow_q   <= wr_en & full_q;
      underflow_q  <= rd_en & rd_empty;
      valid_q      <= valid_d;
    end
  end

`ifdef FIFO_PEAK_LEVEL_EN
  logic [addr_width:0] peak_q;

  // peak_clr wins over the high-water update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      peak_q <= '0;
    end else if (peak_clr) begin
      peak_q <= level_q;
    end else if (level_d > peak_q) begin
      peak_q <= level_d;
    end
  end

  assign peak_level = peak_q;
`endif

  assign full       = full_q;
  assign prog_full  = prog_full_q;
  assign prog_empty = prog_empty_q;
  assign wr_ack     = wr_ack_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
  assign valid      = valid_q;
  assign dout       = dout_q;
  assign empty      = rd_empty;
  assign level      = level_q;

endmodule
